// File: rtl/wb_core_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS core-side masters share one slave port.
// The grant is locked for the whole cyc of the winner; a stall timeout aborts hung strobes.
module wb_core_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk_core,
  input  logic                              rst_core,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_data_o,
  input  logic [DATA_WIDTH-1:0]             s_data_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]          win;
  logic                   found;
  logic                   expire;

  // Slave side mirrors the granted master; grant_q is zero outside GRANTED.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_cyc_o  = s_cyc_o | m_cyc_i[i];
        s_stb_o  = s_stb_o | m_stb_i[i];
        s_we_o   = s_we_o  | m_we_i[i];
        s_addr_o = s_addr_o | m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_data_o = s_data_o | m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // An ack landing in the expiry cycle wins over the timeout.
  assign expire   = (TIMEOUT_CYCLES > 0) && (state_q == GRANTED) && s_cyc_o &&
                    s_stb_o && !s_ack_i && (cnt_q == TMO);
  assign m_ack_o  = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_err_o  = grant_q & {NUM_MASTERS{expire}};
  assign m_data_o = s_data_i;
  assign grant_o  = grant_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!found && m_cyc_i[(int'(last_q) + k) % NUM_MASTERS]) begin
        found = 1'b1;
        win   = LW'((int'(last_q) + k) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          last_d       = win;
          state_d      = GRANTED;
        end
      end
      GRANTED: begin
        if (!s_cyc_o) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (expire) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = ABORT;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (s_stb_o && (TIMEOUT_CYCLES > 0)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_core_arbiter.sv
// Directed and random checks of wb_core_arbiter against an owner/wait-count reference model.
module tb_wb_core_arbiter;
  localparam int N = 2, AW = 32, DW = 32, T = 4;

  logic            clk_core = 1'b0;
  logic            rst_core;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_data_i;
  logic [DW-1:0]   m_data_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_data_o, s_data_i;
  logic            s_ack_i;

  int checks = 0;
  int errors = 0;
  // Reference model: owner = granted master (-1 if none), wcnt = stalled cycles so far.
  int owner = -1, last = N - 1, wcnt = 0;
  bit abort_cyc = 0;

  wb_core_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge and compare every output with the model.
  task automatic smp();
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat;
    @(negedge clk_core);
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_wdat = '0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      e_cyc  = m_cyc_i[owner];
      e_stb  = m_stb_i[owner];
      e_we   = m_we_i[owner];
      e_addr = m_addr_i[owner*AW +: AW];
      e_wdat = m_data_i[owner*DW +: DW];
      e_ack[owner] = s_ack_i;
      e_err[owner] = (wcnt == T) && e_cyc && e_stb && !s_ack_i;
    end
    chk("m_grant", grant_o, e_grant);
    chk("m_scyc", s_cyc_o, e_cyc);
    chk("m_sstb", s_stb_o, e_stb);
    chk("m_swe", s_we_o, e_we);
    chk("m_saddr", s_addr_o, e_addr);
    chk("m_sdata", s_data_o, e_wdat);
    chk("m_ack", m_ack_o, e_ack);
    chk("m_err", m_err_o, e_err);
    chk("m_rdata", m_data_o, s_data_i);
  endtask

  // Advance the model with the current inputs, then take the clock edge.
  task automatic adv();
    bit found;
    if (rst_core) begin
      owner = -1; last = N - 1; wcnt = 0; abort_cyc = 0;
    end else if (abort_cyc) begin
      abort_cyc = 0;
    end else if (owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && m_cyc_i[(last + k) % N]) begin
          found = 1;
          owner = (last + k) % N;
        end
      end
      if (found) last = owner;
      wcnt = 0;
    end else if (!m_cyc_i[owner]) begin
      owner = -1; wcnt = 0;
    end else if (wcnt == T && m_stb_i[owner] && !s_ack_i) begin
      owner = -1; wcnt = 0; abort_cyc = 1;
    end else if (s_ack_i) begin
      wcnt = 0;
    end else if (m_stb_i[owner]) begin
      wcnt++;
    end
    @(posedge clk_core);
    #1;
  endtask

  initial begin
    logic [N-1:0] one;
    rst_core = 1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_data_i = '0; s_data_i = '0; s_ack_i = 0;
    @(posedge clk_core); #1;
    adv();
    rst_core = 0;
    smp();
    chk("rst_grant", grant_o, 0); chk("rst_scyc", s_cyc_o, 0);
    chk("rst_ack", m_ack_o, 0); chk("rst_err", m_err_o, 0);
    adv();

    // Round-robin: both request continuously, each releases after one ack.
    for (int r = 0; r < 4; r++) begin
      one = N'(1) << (r % 2);
      m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 0;
      smp(); chk("rr_idle", grant_o, 0); adv();
      s_ack_i = 1;
      smp(); chk("rr_grant", grant_o, one); chk("rr_ack", m_ack_o, one); adv();
      m_cyc_i = ~one; m_stb_i = ~one; s_ack_i = 0;
      smp(); chk("rr_release", s_cyc_o, 0); adv();
    end

    // Single master read, slave acks two cycles after strobe.
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_addr_i[0 +: AW] = 32'h0000_0100;
    smp(); chk("sm_idle", grant_o, 0); adv();
    smp(); chk("sm_grant", grant_o, 2'b01); chk("sm_addr", s_addr_o, 32'h100); adv();
    smp(); chk("sm_noack", m_ack_o, 0); adv();
    s_ack_i = 1; s_data_i = 32'hDEADBEEF;
    smp(); chk("sm_ack", m_ack_o, 2'b01); chk("sm_rdata", m_data_o, 32'hDEADBEEF); adv();
    s_ack_i = 0; m_cyc_i = 0; m_stb_i = 0;
    smp(); chk("sm_scyc_drop", s_cyc_o, 0); adv();
    smp(); chk("sm_grant_clr", grant_o, 0); adv();

    // Lock: m1 holds cyc over three acked strobes while m0 waits.
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_addr_i[0 +: AW] = 32'h300;
    m_addr_i[AW +: AW] = 32'h200;
    smp(); adv();
    for (int k = 0; k < 3; k++) begin
      m_addr_i[AW +: AW] = 32'h200 + 32'(4 * k); s_ack_i = 1;
      smp(); chk("lk_grant", grant_o, 2'b10); chk("lk_addr", s_addr_o, 32'h200 + 32'(4 * k)); adv();
    end
    s_ack_i = 0; m_cyc_i = 2'b01; m_stb_i = 2'b01;
    smp(); chk("lk_hold", grant_o, 2'b10); adv();
    smp(); chk("lk_idle", grant_o, 0); adv();
    s_ack_i = 1;
    smp(); chk("lk_m0", grant_o, 2'b01); chk("lk_m0addr", s_addr_o, 32'h300); adv();
    s_ack_i = 0; m_cyc_i = 0; m_stb_i = 0;
    smp(); adv();

    // Timeout: slave never acks.
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    smp(); chk("to_idle", grant_o, 0); adv();
    for (int k = 0; k < 4; k++) begin
      smp(); chk("to_stb", s_stb_o, 1); chk("to_noerr", m_err_o, 0); adv();
    end
    smp(); chk("to_err", m_err_o, 2'b01); adv();
    smp(); chk("to_abort_cyc", s_cyc_o, 0); chk("to_abort_err", m_err_o, 0); adv();
    smp(); chk("to_reidle", grant_o, 0); adv();

    // Ack in the expiry cycle wins.
    for (int k = 0; k < 4; k++) begin
      smp(); chk("ae_grant", grant_o, 2'b01); chk("ae_noerr", m_err_o, 0); adv();
    end
    s_ack_i = 1;
    smp(); chk("ae_ack", m_ack_o, 2'b01); chk("ae_err", m_err_o, 0); adv();
    s_ack_i = 0;
    smp(); chk("ae_noabort", s_cyc_o, 1); chk("ae_hold", grant_o, 2'b01); adv();
    m_cyc_i = 0; m_stb_i = 0;
    smp(); adv();

    // Reset while m1 is granted.
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    smp(); adv();
    smp(); chk("rm_grant", grant_o, 2'b10); adv();
    rst_core = 1;
    smp(); adv();
    rst_core = 0; m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1;
    smp(); chk("rm_grant0", grant_o, 0); chk("rm_scyc", s_cyc_o, 0);
    chk("rm_ack", m_ack_o, 0); chk("rm_err", m_err_o, 0); adv();
    s_ack_i = 0;
    smp(); chk("rm_first", grant_o, 2'b01); adv();

    // Random traffic against the model.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) m_cyc_i[i] = ~m_cyc_i[i];
      m_stb_i  = N'($urandom);
      m_we_i   = N'($urandom);
      m_addr_i = {$urandom, $urandom};
      m_data_i = {$urandom, $urandom};
      s_data_i = $urandom;
      s_ack_i  = ($urandom_range(9) < 3);
      rst_core = ($urandom_range(149) == 0);
      smp(); adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
